// File: rtl/key_repeat_debouncer_pkg.sv
// key_repeat_debouncer_pkg: shared FSM state encoding and counter width helper for the key debouncer.
// Ports: none. Imported by key_channel_fsm and key_repeat_debouncer.
package key_repeat_debouncer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2,
        REL_DB = 2'd3
    } key_state_t;

    // Bits needed to hold values 0..max_val, never less than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/key_repeat_debouncer_key_channel_fsm.sv
// key_channel_fsm: synchroniser, debounce/auto-repeat FSM, counters and registered outputs for one key.
// Ports: clk, rst (sync, active-high); i_tick shared sample strobe; i_raw raw key (1 = pressed);
//        o_level debounced level; o_press / o_release single-cycle pulses.
// Config: KEY_AUTOREPEAT_EN builds the hold/repeat counters and the REPEAT state.
module key_channel_fsm
    import key_repeat_debouncer_pkg::*;
#(
    parameter int DB_TICKS = 16
`ifdef KEY_AUTOREPEAT_EN
    ,
    parameter int HOLD_TICKS = 500,
    parameter int REPEAT_TICKS = 100
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic i_tick,
    input  logic i_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam int DBW = cnt_width(DB_TICKS);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_TICKS - 1);

    logic r_s1;
    logic r_s2;
    key_state_t r_state;
    logic [DBW-1:0] r_db_cnt;

`ifdef KEY_AUTOREPEAT_EN
    localparam int HW = cnt_width(HOLD_TICKS);
    localparam int RW = cnt_width(REPEAT_TICKS);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS - 1);
    logic [HW-1:0] r_hold_cnt;
    logic [RW-1:0] r_rep_cnt;
`endif

    // Counters compare against terminal-1 because the deciding tick is the one
    // that would bring them to the terminal value; they are cleared on exit, so
    // they never wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_state   <= IDLE;
            r_db_cnt  <= '0;
            o_level   <= 1'b0;
            o_press   <= 1'b0;
            o_release <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
            r_hold_cnt <= '0;
            r_rep_cnt  <= '0;
`endif
        end else begin
            r_s1      <= i_raw;
            r_s2      <= r_s1;
            o_press   <= 1'b0;
            o_release <= 1'b0;
            if (i_tick) begin
                case (r_state)
                    IDLE: begin
                        if (!r_s2) r_db_cnt <= '0;
                        else if (r_db_cnt >= DB_LAST) begin
                            r_db_cnt <= '0;
                            o_level  <= 1'b1;
                            o_press  <= 1'b1;
                            r_state  <= HELD;
`ifdef KEY_AUTOREPEAT_EN
                            r_hold_cnt <= '0;
`endif
                        end else r_db_cnt <= r_db_cnt + 1'b1;
                    end
                    HELD: begin
                        if (!r_s2) begin
                            r_db_cnt <= DBW'(1);
                            r_state  <= REL_DB;
                        end
`ifdef KEY_AUTOREPEAT_EN
                        else if (r_hold_cnt >= HOLD_LAST) begin
                            o_press   <= 1'b1;
                            r_rep_cnt <= '0;
                            r_state   <= REPEAT;
                        end else r_hold_cnt <= r_hold_cnt + 1'b1;
`endif
                    end
`ifdef KEY_AUTOREPEAT_EN
                    REPEAT: begin
                        if (!r_s2) begin
                            r_db_cnt <= DBW'(1);
                            r_state  <= REL_DB;
                        end else if (r_rep_cnt >= REP_LAST) begin
                            o_press   <= 1'b1;
                            r_rep_cnt <= '0;
                        end else r_rep_cnt <= r_rep_cnt + 1'b1;
                    end
`endif
                    REL_DB: begin
                        // A bounce back to pressed silently returns to HELD and restarts the hold delay.
                        if (r_s2) begin
                            r_db_cnt <= '0;
                            r_state  <= HELD;
`ifdef KEY_AUTOREPEAT_EN
                            r_hold_cnt <= '0;
`endif
                        end else if (r_db_cnt >= DB_LAST) begin
                            r_db_cnt  <= '0;
                            o_level   <= 1'b0;
                            o_release <= 1'b1;
                            r_state   <= IDLE;
                        end else r_db_cnt <= r_db_cnt + 1'b1;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/key_repeat_debouncer.sv
// key_repeat_debouncer: N-key synchronise/debounce front-end with press/release pulses and optional auto-repeat.
// Ports: clk; rst (sync, active-high); key_raw[N_KEYS] raw keys (1 = pressed);
//        key_level[N_KEYS] debounced level; key_press / key_release[N_KEYS] single-cycle pulses.
// Config: define KEY_AUTOREPEAT_EN to re-fire key_press while a key is held.
module key_repeat_debouncer
    import key_repeat_debouncer_pkg::*;
#(
    parameter int N_KEYS       = 2,
    parameter int SAMPLE_DIV   = 50000,
    parameter int DB_TICKS     = 16,
    parameter int HOLD_TICKS   = 500,
    parameter int REPEAT_TICKS = 100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_raw,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release
);

    localparam int DIVW = cnt_width(SAMPLE_DIV - 1);
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(SAMPLE_DIV - 1);

    if (SAMPLE_DIV < 2 || DB_TICKS < 1 || HOLD_TICKS < 1 || REPEAT_TICKS < 1) begin : g_param_err
        $error("key_repeat_debouncer: SAMPLE_DIV must be >= 2 and tick counts >= 1");
    end

    logic [DIVW-1:0] r_div;
    logic            w_tick;

    assign w_tick = (r_div == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst) r_div <= '0;
        else r_div <= w_tick ? '0 : r_div + 1'b1;
    end

    for (genvar k = 0; k < N_KEYS; k++) begin : g_key
        key_channel_fsm #(
            .DB_TICKS(DB_TICKS)
`ifdef KEY_AUTOREPEAT_EN
            ,
            .HOLD_TICKS(HOLD_TICKS),
            .REPEAT_TICKS(REPEAT_TICKS)
`endif
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .i_tick   (w_tick),
            .i_raw    (key_raw[k]),
            .o_level  (key_level[k]),
            .o_press  (key_press[k]),
            .o_release(key_release[k])
        );
    end

endmodule

// File: tb/tb_key_repeat_debouncer.sv
// tb_key_repeat_debouncer: directed self-checking bench (SAMPLE_DIV=4, DB_TICKS=3, HOLD_TICKS=10, REPEAT_TICKS=4).
module tb_key_repeat_debouncer;

`ifdef KEY_AUTOREPEAT_EN
    localparam int AR = 1;
`else
    localparam int AR = 0;
`endif

    logic       clk;
    logic       rst;
    logic [1:0] key_raw;
    logic [1:0] key_level;
    logic [1:0] key_press;
    logic [1:0] key_release;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int pc0 = 0, pc1 = 0, rc0 = 0, rc1 = 0, both_cnt = 0;
    int sp0, sp1, sr0, sr1;

    key_repeat_debouncer #(
        .N_KEYS(2),
        .SAMPLE_DIV(4),
        .DB_TICKS(3),
        .HOLD_TICKS(10),
        .REPEAT_TICKS(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key_raw(key_raw),
        .key_level(key_level),
        .key_press(key_press),
        .key_release(key_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Posedges since reset release (tick edges are where cyc % 4 == 0) and pulse tallies.
    always @(posedge clk) begin
        cyc <= rst ? 0 : cyc + 1;
        if (key_press[0] === 1'b1) pc0 <= pc0 + 1;
        if (key_press[1] === 1'b1) pc1 <= pc1 + 1;
        if (key_release[0] === 1'b1) rc0 <= rc0 + 1;
        if (key_release[1] === 1'b1) rc1 <= rc1 + 1;
        if (|(key_press & key_release) === 1'b1) both_cnt <= both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Land on the negedge right after a tick edge.
    task automatic align();
        do @(negedge clk); while (cyc % 4 != 0);
    endtask

    task automatic snap();
        sp0 = pc0; sp1 = pc1; sr0 = rc0; sr1 = rc1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset with both keys held, then re-debounce after release of reset
        rst = 1'b1;
        key_raw = 2'b11;
        wait_clk(3);
        chk("rst_level", 32'(key_level), 32'd0);
        chk("rst_press", 32'(key_press), 32'd0);
        chk("rst_release", 32'(key_release), 32'd0);
        rst = 1'b0;
        wait_clk(11);
        chk("rst_press_early", 32'(key_press), 32'd0);
        wait_clk(1);
        chk("rst_press_both", 32'(key_press), 32'd3);
        chk("rst_level_both", 32'(key_level), 32'd3);
        key_raw = 2'b00;
        wait_clk(40);
        chk("rst_drain_level", 32'(key_level), 32'd0);
        // 2: clean press on key0
        snap();
        key_raw = 2'b01;
        wait_clk(20);
        chk("clean_level", 32'(key_level[0]), 32'd1);
        chk("clean_press_cnt", 32'(pc0 - sp0), 32'd1);
        chk("clean_no_release", 32'(rc0 - sr0), 32'd0);
        key_raw = 2'b00;
        wait_clk(40);
        chk("clean_release_cnt", 32'(rc0 - sr0), 32'd1);
        chk("clean_level_off", 32'(key_level[0]), 32'd0);
        chk("clean_key1_idle", 32'(pc1 - sp1), 32'd0);
        // 3: bounce on key0 never qualifies
        snap();
        for (int i = 0; i < 13; i++) begin
            key_raw[0] = ~key_raw[0];
            wait_clk(3);
        end
        chk("bounce_level_mid", 32'(key_level[0]), 32'd0);
        key_raw = 2'b00;
        wait_clk(40);
        chk("bounce_press_cnt", 32'(pc0 - sp0), 32'd0);
        chk("bounce_release_cnt", 32'(rc0 - sr0), 32'd0);
        chk("bounce_level", 32'(key_level[0]), 32'd0);
        // 4: long hold on key0 for 100 clk from a tick-aligned start
        align();
        snap();
        key_raw = 2'b01;
        wait_clk(11);
        chk("hold_press_early", 32'(key_press[0]), 32'd0);
        wait_clk(1);
        chk("hold_press_tick3", 32'(key_press[0]), 32'd1);
        chk("hold_level", 32'(key_level[0]), 32'd1);
        wait_clk(39);
        chk("hold_pre_repeat", 32'(key_press[0]), 32'd0);
        wait_clk(1);
        chk("hold_first_repeat", 32'(key_press[0]), 32'(AR));
        wait_clk(48);
        key_raw = 2'b00;
        wait_clk(40);
        chk("hold_press_total", 32'(pc0 - sp0), 32'(AR ? 5 : 1));
        chk("hold_release_cnt", 32'(rc0 - sr0), 32'd1);
        chk("hold_level_off", 32'(key_level[0]), 32'd0);
        // 5: release glitch on key1 restarts the hold delay and emits nothing
        align();
        snap();
        key_raw = 2'b10;
        wait_clk(12);
        chk("glitch_press", 32'(key_press[1]), 32'd1);
        wait_clk(8);
        key_raw = 2'b00;
        wait_clk(4);
        key_raw = 2'b10;
        wait_clk(36);
        chk("glitch_no_release", 32'(rc1 - sr1), 32'd0);
        chk("glitch_level", 32'(key_level[1]), 32'd1);
        chk("glitch_hold_restart", 32'(pc1 - sp1), 32'd1);
        wait_clk(8);
        chk("glitch_late_repeat", 32'(key_press[1]), 32'(AR));
        key_raw = 2'b00;
        wait_clk(11);
        chk("glitch_rel_early", 32'(key_release[1]), 32'd0);
        chk("glitch_level_pre", 32'(key_level[1]), 32'd1);
        wait_clk(1);
        chk("glitch_release", 32'(key_release[1]), 32'd1);
        chk("glitch_level_off", 32'(key_level[1]), 32'd0);
        chk("glitch_excl", 32'(key_press[1]), 32'd0);
        // 6: simultaneous press, then reset in the middle of repeat
        align();
        key_raw = 2'b11;
        wait_clk(12);
        chk("simul_press", 32'(key_press), 32'd3);
        wait_clk(40);
        chk("simul_repeat", 32'(key_press), 32'(AR ? 3 : 0));
        wait_clk(2);
        rst = 1'b1;
        wait_clk(1);
        chk("midrst_level", 32'(key_level), 32'd0);
        chk("midrst_press", 32'(key_press), 32'd0);
        chk("midrst_release", 32'(key_release), 32'd0);
        rst = 1'b0;
        wait_clk(11);
        chk("midrst_idle_press", 32'(key_press), 32'd0);
        chk("midrst_idle_level", 32'(key_level), 32'd0);
        wait_clk(1);
        chk("midrst_repress", 32'(key_press), 32'd3);
        key_raw = 2'b00;
        wait_clk(40);
        chk("final_level", 32'(key_level), 32'd0);
        chk("press_release_excl", 32'(both_cnt), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
